// File: rtl/word_serializer_pkg.sv
// Shared types for the word serializer and its companion verifier block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package word_serializer_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        SER_IDLE  = 2'd0,
        SER_FETCH = 2'd1,
        SER_LOAD  = 2'd2,
        SER_SHIFT = 2'd3
    } Serializer_state;

    typedef enum logic [1:0] {
        VER_IDLE    = 2'd0,
        VER_COMPARE = 2'd1,
        VER_REPORT  = 2'd2
    } Verifier_state;

endpackage

// File: rtl/word_serializer_if.sv
// FIFO read port between the serializer (master) and a 32-bit word FIFO (slave).
// Latency: read data valid one cycle after o_fifo_rd_en.
// Backpressure: the master only pops while i_fifo_empty is low.
interface word_serializer_if;

    logic        o_fifo_rd_en;
    logic        i_fifo_empty;
    logic [31:0] i_fifo_rd_data;

    modport master (
        output o_fifo_rd_en,
        input  i_fifo_empty,
        input  i_fifo_rd_data
    );

    modport slave (
        input  o_fifo_rd_en,
        output i_fifo_empty,
        output i_fifo_rd_data
    );

endinterface

// File: rtl/word_serializer.sv
// Pops 32-bit words from a FIFO and emits a programmed number of bytes, one per cycle.
// Latency: first byte 3 cycles after i_start (fetch, load, shift); o_done one cycle after the last byte.
// Backpressure: stalls in SER_FETCH while the FIFO is empty; macro SERIALIZER_LSB_FIRST_EN selects LSB-first order.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int LEN_W = 6
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  i_start,
    input  logic [LEN_W-1:0]      i_RCC_BUFFER_LENGTH,
    word_serializer_if.master     fifo,
    output logic [BYTE_W-1:0]     o_serialized_output,
    output logic                  o_serialized_output_valid,
    output logic [1:0]            o_serialize_counter,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int CNT_W = LEN_W + 1;

    Serializer_state     state;
    Serializer_state     state_nxt;

    logic [WORD_W-1:0]   word_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    byte_cnt;
    logic [1:0]          ser_cnt;
    logic [BYTE_W-1:0]   last_byte;
    logic                done_q;
    logic                pf_q;

    logic [BYTE_W-1:0]   cur_byte;
    logic [CNT_W-1:0]    byte_cnt_x;
    logic [CNT_W-1:0]    len_x;
    logic                is_last;
    logic                more_words;
    logic                rd_en;
    logic                load_word;
    logic                accept;
    logic                done_nxt;
    logic                pf_set;

    // Byte-select mux: the counter picks one byte lane of the current word.
    always_comb begin
        cur_byte = '0;
        case (ser_cnt)
`ifdef SERIALIZER_LSB_FIRST_EN
            2'd0:    cur_byte = word_q[7:0];
            2'd1:    cur_byte = word_q[15:8];
            2'd2:    cur_byte = word_q[23:16];
            default: cur_byte = word_q[31:24];
`else
            2'd0:    cur_byte = word_q[31:24];
            2'd1:    cur_byte = word_q[23:16];
            2'd2:    cur_byte = word_q[15:8];
            default: cur_byte = word_q[7:0];
`endif
        endcase
    end

    // Extended-width compares so byte_cnt + 2 cannot wrap near the maximum length.
    assign byte_cnt_x = {1'b0, byte_cnt};
    assign len_x      = {1'b0, len_q};
    assign is_last    = (byte_cnt_x + CNT_W'(1)) == len_x;
    assign more_words = (byte_cnt_x + CNT_W'(2)) < len_x;

    // Next-state and control: fetch/load a word, shift four bytes, prefetch on index 2.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        load_word = 1'b0;
        accept    = 1'b0;
        done_nxt  = 1'b0;
        pf_set    = 1'b0;
        case (state)
            SER_IDLE: begin
                if (i_start) begin
                    if (i_RCC_BUFFER_LENGTH == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = SER_FETCH;
                    end
                end
            end
            SER_FETCH: begin
                rd_en = !fifo.i_fifo_empty;
                if (!fifo.i_fifo_empty) begin
                    state_nxt = SER_LOAD;
                end
            end
            SER_LOAD: begin
                load_word = 1'b1;
                state_nxt = SER_SHIFT;
            end
            SER_SHIFT: begin
                if (is_last) begin
                    state_nxt = SER_IDLE;
                    done_nxt  = 1'b1;
                end else if (ser_cnt == 2'd2) begin
                    if (more_words && !fifo.i_fifo_empty) begin
                        rd_en  = 1'b1;
                        pf_set = 1'b1;
                    end
                end else if (ser_cnt == 2'd3) begin
                    if (pf_q) begin
                        load_word = 1'b1;
                    end else begin
                        state_nxt = SER_FETCH;
                    end
                end
            end
            default: state_nxt = SER_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= SER_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: length/byte counters, word register, held output byte and done pulse.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            word_q    <= '0;
            len_q     <= '0;
            byte_cnt  <= '0;
            ser_cnt   <= '0;
            last_byte <= '0;
            done_q    <= 1'b0;
            pf_q      <= 1'b0;
        end else begin
            done_q <= done_nxt;
            if (accept) begin
                len_q    <= i_RCC_BUFFER_LENGTH;
                byte_cnt <= '0;
                ser_cnt  <= '0;
            end
            if (state == SER_SHIFT) begin
                byte_cnt  <= byte_cnt + LEN_W'(1);
                ser_cnt   <= ser_cnt + 2'd1;
                last_byte <= cur_byte;
                pf_q      <= pf_set;
            end
            if (load_word) begin
                word_q  <= fifo.i_fifo_rd_data;
                ser_cnt <= '0;
            end
        end
    end

    // A pop requested while reset is being applied would be discarded, so suppress it.
    assign fifo.o_fifo_rd_en        = rd_en && !RESET;

    assign o_serialized_output       = (state == SER_SHIFT) ? cur_byte : last_byte;
    assign o_serialized_output_valid = (state == SER_SHIFT);
    assign o_serialize_counter       = ser_cnt;
    assign o_busy                    = (state != SER_IDLE);
    assign o_done                    = done_q;

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer: scoreboard of expected bytes, FIFO model, directed transfers.
// Latency: checks first byte, gapless prefetch, bubble on empty FIFO and o_done one cycle after the last byte.
// Backpressure: FIFO model withholds words to force the fetch stall path.
module tb_word_serializer;

    localparam int LEN_W = 6;

    typedef struct packed {
        logic [7:0] b;
        logic [1:0] c;
    } exp_t;

    logic             CLK = 1'b0;
    logic             RESET = 1'b1;
    logic             i_start = 1'b0;
    logic [LEN_W-1:0] i_len = '0;
    logic [7:0]       ser_out;
    logic             ser_vld;
    logic [1:0]       ser_cnt;
    logic             busy;
    logic             done;

    word_serializer_if fifo ();

    word_serializer #(.LEN_W(LEN_W)) dut (
        .CLK                       (CLK),
        .RESET                     (RESET),
        .i_start                   (i_start),
        .i_RCC_BUFFER_LENGTH       (i_len),
        .fifo                      (fifo),
        .o_serialized_output       (ser_out),
        .o_serialized_output_valid (ser_vld),
        .o_serialize_counter       (ser_cnt),
        .o_busy                    (busy),
        .o_done                    (done)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int total = 0;
    int failc = 0;

    // FIFO model: one-cycle read latency, counts pops and illegal pops.
    logic [31:0] fq[$];
    int          fq_cnt = 0;
    int          pop_cnt = 0;
    int          rd_while_empty = 0;
    logic [31:0] rd_data_q = '0;

    assign fifo.i_fifo_empty   = (fq_cnt == 0);
    assign fifo.i_fifo_rd_data = rd_data_q;

    always @(posedge CLK) begin
        if (fifo.o_fifo_rd_en) begin
            if (fq_cnt == 0) begin
                rd_while_empty++;
            end else begin
                rd_data_q <= fq.pop_front();
                fq_cnt--;
                pop_cnt++;
            end
        end
    end

    // Scoreboard monitor.
    exp_t expq[$];
    int   vcyc[$];
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   busy_seen = 0;

    always @(negedge CLK) begin
        exp_t e;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy === 1'b1) busy_seen++;
        if (ser_vld === 1'b1) begin
            vcyc.push_back(cyc);
            total++;
            if (expq.size() == 0) begin
                failc++;
                $display("FAIL unexpected_byte: got byte %02h idx %0d, required no valid byte", ser_out, ser_cnt);
            end else begin
                e = expq.pop_front();
                if (ser_out !== e.b || ser_cnt !== e.c) begin
                    failc++;
                    $display("FAIL byte: got %02h idx %0d, required %02h idx %0d", ser_out, ser_cnt, e.b, e.c);
                end
            end
        end
    end

    function automatic logic [7:0] exp_byte(input logic [31:0] w, input int i);
        logic [31:0] t;
`ifdef SERIALIZER_LSB_FIRST_EN
        t = w >> (8 * i);
`else
        t = w >> (8 * (3 - i));
`endif
        return t[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            failc++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic sb_word(input logic [31:0] w, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.b = exp_byte(w, i);
            e.c = 2'(i);
            expq.push_back(e);
        end
    endtask

    task automatic push_fifo(input logic [31:0] w);
        fq.push_back(w);
        fq_cnt++;
    endtask

    task automatic clear_stats();
        vcyc.delete();
        pop_cnt   = 0;
        done_cnt  = 0;
        busy_seen = 0;
    endtask

    int start_cyc = 0;

    task automatic start_xfer(input int len);
        @(posedge CLK);
        #1;
        i_len     = LEN_W'(len);
        i_start   = 1'b1;
        start_cyc = cyc;
        @(posedge CLK);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 300) begin
            @(posedge CLK);
            n++;
        end
        check({name, "_done_seen"}, (done_cnt > 0), 1);
        repeat (6) @(posedge CLK);
        check({name, "_done_once"}, done_cnt, 1);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_out", ser_out, 0);
        check("rst_vld", ser_vld, 0);
        check("rst_cnt", ser_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", fifo.o_fifo_rd_en, 0);
        RESET = 1'b0;

        // Length 8, FIFO always non-empty: 8 gapless bytes.
        clear_stats();
        push_fifo(32'h11223344);
        push_fifo(32'h55667788);
        sb_word(32'h11223344, 4);
        sb_word(32'h55667788, 4);
        start_xfer(8);
        wait_done("t1");
        check("t1_pops", pop_cnt, 2);
        check("t1_nbytes", vcyc.size(), 8);
        check("t1_gapless", vcyc[7] - vcyc[0], 7);
        check("t1_done_cyc", done_cyc, vcyc[7] + 1);
        check("t1_sb_empty", expq.size(), 0);

        // Length 6: trailing two bytes of the second word are dropped.
        clear_stats();
        push_fifo(32'h11223344);
        push_fifo(32'h55667788);
        sb_word(32'h11223344, 4);
        sb_word(32'h55667788, 2);
        start_xfer(6);
        wait_done("t2");
        check("t2_pops", pop_cnt, 2);
        check("t2_nbytes", vcyc.size(), 6);
        check("t2_fifo_left", fq_cnt, 0);
        check("t2_done_cyc", done_cyc, vcyc[5] + 1);

        // Length 8 with the second word arriving late: bubble after 0x44.
        clear_stats();
        push_fifo(32'h11223344);
        sb_word(32'h11223344, 4);
        sb_word(32'h55667788, 4);
        start_xfer(8);
        n = 0;
        while (pop_cnt == 0 && n < 100) begin
            @(posedge CLK);
            n++;
        end
        check("t3_first_pop", pop_cnt, 1);
        repeat (5) @(posedge CLK);
        #1;
        push_fifo(32'h55667788);
        wait_done("t3");
        check("t3_nbytes", vcyc.size(), 8);
        check("t3_bubble", (vcyc[4] - vcyc[3] > 1), 1);
        check("t3_pops", pop_cnt, 2);

        // Length 0: no pop, no busy, done one cycle after start.
        clear_stats();
        push_fifo(32'hDEADBEEF);
        start_xfer(0);
        repeat (5) @(posedge CLK);
        check("t4_done_cnt", done_cnt, 1);
        check("t4_done_cyc", done_cyc, start_cyc + 1);
        check("t4_busy", busy_seen, 0);
        check("t4_pops", pop_cnt, 0);
        fq.delete();
        fq_cnt = 0;

        // Reset after the third byte of a length-8 transfer.
        clear_stats();
        push_fifo(32'h11223344);
        push_fifo(32'h55667788);
        sb_word(32'h11223344, 4);
        sb_word(32'h55667788, 4);
        start_xfer(8);
        n = 0;
        while (vcyc.size() < 3 && n < 100) begin
            @(negedge CLK);
            #1;
            n++;
        end
        check("t5_three_bytes", vcyc.size(), 3);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        check("t5_out", ser_out, 0);
        check("t5_vld", ser_vld, 0);
        check("t5_cnt", ser_cnt, 0);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        RESET = 1'b0;
        expq.delete();
        fq.delete();
        fq_cnt = 0;
        repeat (3) @(posedge CLK);
        check("t5_no_done", done_cnt, 0);

        // Fresh transfer after reset, length 4 (byte order follows the build option).
        clear_stats();
        push_fifo(32'h11223344);
        sb_word(32'h11223344, 4);
        start_xfer(4);
        wait_done("t6");
        check("t6_pops", pop_cnt, 1);
        check("t6_nbytes", vcyc.size(), 4);
        check("t6_sb_empty", expq.size(), 0);

        check("rd_en_while_empty", rd_while_empty, 0);

        $display("%0d/%0d checks passed", total - failc, total);
        $finish;
    end

endmodule

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 SHALL have parameter LEN_W, default 6, width of the byte-length input.
REQ-002 SHALL have port CLK, input, 1, sole clock; all logic on posedge.
REQ-003 SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-004 SHALL have port i_start, input, 1, single-cycle transfer request.
REQ-005 SHALL have port i_RCC_BUFFER_LENGTH, input, LEN_W, transfer length in bytes, sampled on an accepted i_start.
REQ-006 SHALL have port i_fifo_empty, input, 1, reader FIFO empty flag.
REQ-007 SHALL have port i_fifo_rd_data, input, 32, FIFO read data, valid one cycle after o_fifo_rd_en.
REQ-008 SHALL have port o_fifo_rd_en, output, 1, FIFO pop strobe.
REQ-009 SHALL have port o_serialized_output, output, 8, current byte.
REQ-010 SHALL have port o_serialized_output_valid, output, 1, byte qualifier.
REQ-011 SHALL have port o_serialize_counter, output, 2, byte index within the current word, 0..3.
REQ-012 SHALL have port o_busy, output, 1, high from i_start acceptance until done.
REQ-013 SHALL have port o_done, output, 1, one-cycle pulse after the last byte.

Function
REQ-014 SHALL implement states SER_IDLE, SER_FETCH, SER_LOAD and SER_SHIFT.
REQ-015 SHALL accept i_start only in SER_IDLE; i_start in any other state is ignored.
REQ-016 SHALL, on accepted i_start with length 0, stay in SER_IDLE, issue no FIFO read, and pulse o_done the next cycle.
REQ-017 SHALL, on accepted i_start with length >0, latch the length, zero the byte counter and enter SER_FETCH.
REQ-018 SHALL, in SER_FETCH, drive o_fifo_rd_en = !i_fifo_empty combinationally and move to SER_LOAD only when a pop occurs; otherwise it waits.
REQ-019 SHALL, in SER_LOAD, capture i_fifo_rd_data into a word register, set the counter to 0 and enter SER_SHIFT.
REQ-020 SHALL, in SER_SHIFT, assert valid for one byte per cycle, with counter 0..3 selecting word[31:24], [23:16], [15:8], [7:0].
REQ-021 SHALL prefetch: while SER_SHIFT emits index 2, and more words are needed and the FIFO is non-empty, assert o_fifo_rd_en and load the new word at the end of the index-3 cycle, so the byte stream has no gap.
REQ-022 SHALL, if the prefetch is not possible because the FIFO is empty, go to SER_FETCH after index 3; valid is low until the next load (a bubble).
REQ-023 SHALL end after exactly length bytes: pop exactly ceil(length/4) words, discard unused trailing bytes of the last word, return to SER_IDLE and pulse o_done the cycle after the final valid byte.
REQ-024 SHALL hold o_serialized_output at its last value when valid is low.
REQ-025 SHALL drive o_busy = (state != SER_IDLE).
REQ-026 SHALL never assert o_fifo_rd_en while i_fifo_empty is high.

Reset
REQ-027 SHALL, on RESET, go to SER_IDLE and clear o_serialized_output, valid, counter, o_done, the word register, the length register and the byte count to 0.
REQ-028 SHALL let RESET mid-transfer abort immediately without o_done; a FIFO word popped the cycle before is discarded.

Configuration
REQ-029 SHALL, with SERIALIZER_LSB_FIRST_EN defined, map index 0..3 to word[7:0], [15:8], [23:16], [31:24].
REQ-030 SHALL use MSB-first order when SERIALIZER_LSB_FIRST_EN is undefined; counter semantics are unchanged.

Structure
REQ-031 SHALL declare the state enum Serializer_state (SER_IDLE, SER_FETCH, SER_LOAD, SER_SHIFT) in the shared package, alongside Verifier_state.
REQ-032 SHALL be one flat module; the byte-select mux is inline and no sub-module is warranted.

Verification
REQ-033 SHALL cover: length 8, FIFO holding 0x11223344 then 0x55667788, always non-empty -> bytes 11,22,33,44,55,66,77,88 on 8 consecutive valid cycles, counters 0..3,0..3, 2 pops, o_done 1 cycle later.
REQ-034 SHALL cover: length 6, same data -> bytes 11..66, 2 pops, bytes 77 and 88 never valid.
REQ-035 SHALL cover: length 8, FIFO empty for 3 cycles after the first word -> valid drops after 0x44 and resumes at 0x55 with counter 0; total 8 valid bytes.
REQ-036 SHALL cover: length 0 -> no o_fifo_rd_en, o_done pulses one cycle after i_start, o_busy stays 0.
REQ-037 SHALL cover: RESET asserted after the 3rd byte of a length-8 transfer -> all outputs 0 the next cycle, no o_done, and a new i_start is accepted correctly.
REQ-038 SHALL cover: SERIALIZER_LSB_FIRST_EN defined, length 4, word 0x11223344 -> bytes 44,33,22,11.
